// File: rtl/mem_arb_pkg.sv
// Shared constants and helpers for the memory arbiter.
// Defaults match the Mem buffer geometry.
package mem_arb_pkg;

    localparam int NUM_REQ_DEF = 4;
    localparam int ADDR_W_DEF  = 10;
    localparam int DATA_W_DEF  = 16;

    // Pointer width; never below one bit.
    function automatic int ptr_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin picker: first request at or after ptr, wrapping.
// Purely combinational; the pointer is held by the caller.
module rr_arbiter
    import mem_arb_pkg::*;
#(
    parameter int N  = NUM_REQ_DEF,
    parameter int PW = ptr_w(NUM_REQ_DEF)
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    input  logic          en,
    output logic [N-1:0]  gnt,
    output logic [PW-1:0] idx,
    output logic          any
);

    logic [PW:0]   sum;
    logic [PW-1:0] pos;

    always_comb begin
        gnt = '0;
        idx = '0;
        any = 1'b0;
        sum = '0;
        pos = '0;
        for (int k = 0; k < N; k++) begin
            sum = {1'b0, ptr} + (PW+1)'(k);
            if (sum >= (PW+1)'(N)) begin
                sum = sum - (PW+1)'(N);
            end
            pos = sum[PW-1:0];
            if (en && !any && req[pos]) begin
                gnt[pos] = 1'b1;
                idx      = pos;
                any      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one Mem write port and one read port among NUM_REQ requesters
// with independent round-robin arbitration per access class.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEF,
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      arb_en,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ-1:0]        req_we,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]         rsp_rdata,
    output logic                      mem_wen,
    output logic [ADDR_W-1:0]         mem_waddr,
    output logic [DATA_W-1:0]         mem_wdata,
    output logic                      mem_ren,
    output logic [ADDR_W-1:0]         mem_raddr,
    input  logic [DATA_W-1:0]         mem_rdata
);

    localparam int PW = ptr_w(NUM_REQ);
    localparam logic [PW-1:0] LAST = PW'(NUM_REQ - 1);

    logic [ADDR_W-1:0] addr_a  [NUM_REQ];
    logic [DATA_W-1:0] wdata_a [NUM_REQ];

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign addr_a[i]  = req_addr[i*ADDR_W +: ADDR_W];
        assign wdata_a[i] = req_wdata[i*DATA_W +: DATA_W];
    end

    logic [PW-1:0]      wr_ptr, rd_ptr;
    logic [NUM_REQ-1:0] wr_gnt, rd_gnt;
    logic [PW-1:0]      wr_idx, rd_idx;
    logic               wr_any, rd_any;
    logic               en;

    // Reset blocks grants even though they are combinational.
    assign en = arb_en & ~rst;

    rr_arbiter #(.N(NUM_REQ), .PW(PW)) u_wr_arb (
        .req (req_valid & req_we),
        .ptr (wr_ptr),
        .en  (en),
        .gnt (wr_gnt),
        .idx (wr_idx),
        .any (wr_any)
    );

    rr_arbiter #(.N(NUM_REQ), .PW(PW)) u_rd_arb (
        .req (req_valid & ~req_we),
        .ptr (rd_ptr),
        .en  (en),
        .gnt (rd_gnt),
        .idx (rd_idx),
        .any (rd_any)
    );

    // Candidate sets are disjoint, so the two grants never collide.
    assign req_ready = wr_gnt | rd_gnt;

    always_comb begin
        mem_wen   = wr_any;
        mem_waddr = '0;
        mem_wdata = '0;
        mem_ren   = rd_any;
        mem_raddr = '0;
        if (wr_any) begin
            mem_waddr = addr_a[wr_idx];
            mem_wdata = wdata_a[wr_idx];
        end
        if (rd_any) begin
            mem_raddr = addr_a[rd_idx];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_any) begin
                wr_ptr <= (wr_idx == LAST) ? '0 : wr_idx + 1'b1;
            end
            if (rd_any) begin
                rd_ptr <= (rd_idx == LAST) ? '0 : rd_idx + 1'b1;
            end
        end
    end

    // Mem reads combinationally, so capturing here gives read-before-write.
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid <= '0;
            rsp_rdata <= '0;
        end else begin
            rsp_valid <= rd_gnt;
            if (rd_any) begin
                rsp_rdata <= mem_rdata;
            end
        end
    end

endmodule
